act_unit_pipe: RTL
==================

Name: act_unit_pipe

Overview:
- Parametrised, pipelined in-place activation engine for the CONV buffer BRAM; next generation of the single-mode ReLU pass.
- Streams one element per cycle and writes the activated value back to the same address through a separate write port.
- Supports a runtime activation mode: ReLU, leaky ReLU, clipped ReLU, or passthrough.
- Supports a runtime active-channel count and a configurable BRAM read latency.

Parameters:
- DATA_WIDTH, 16, signed fixed-point element width.
- CHANNELS, 8, maximum number of channels held in the buffer.
- IMG_SIZE, 28, feature-map height and width.
- RD_LATENCY, 1, BRAM read latency in cycles from r_en to valid r_q (legal values 1..3).
- LEAKY_SHIFT, 3, leaky slope is 2^-LEAKY_SHIFT, implemented as an arithmetic right shift.
- CLIP_MAX, 1536, clipped-ReLU ceiling as a positive signed value (6.0 in Q8.8).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a pass; ignored unless IDLE.
- mode  in  2  0=ReLU, 1=leaky, 2=clip, 3=passthrough; latched when start is accepted.
- active_ch  in  $clog2(CHANNELS+1)  number of channels to process; latched at start.
- conv_r_addr  out  AW  read address, where AW=$clog2(CHANNELS*IMG_SIZE*IMG_SIZE).
- conv_r_en  out  1  read enable.
- conv_r_q  in  DATA_WIDTH  signed read data, valid RD_LATENCY cycles after conv_r_en.
- conv_w_addr  out  AW  write address.
- conv_w_en  out  1  write-port enable.
- conv_w_we  out  1  write strobe.
- conv_w_d  out  DATA_WIDTH  signed activated data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- neg_count  out  AW+1  number of negative inputs seen in the last pass (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, state IDLE, read and write pipelines flushed.
- Reset mid-pass: enables drop at the next edge, no done pulse is issued, and the BRAM contents are left partially processed.
- Effective channel count: N_CH = active_ch, except active_ch==0 or active_ch>CHANNELS, which clamp to CHANNELS.
- Element count: N = N_CH*IMG_SIZE*IMG_SIZE; addresses 0..N-1 in linear order (ch*IMG_SIZE+row)*IMG_SIZE+col.
- State IDLE: on start, latch mode and N_CH, go to RUN, assert busy.
- State RUN: conv_r_en=1 every cycle with conv_r_addr=0,1,...,N-1, so N consecutive cycles starting the cycle after start. After issuing N-1, go to DRAIN.
- Valid pipeline: a valid/address shift register of depth RD_LATENCY tracks in-flight reads. When data emerges, the activation is computed combinationally and registered. conv_w_en=conv_w_we=1 one cycle later with the matching address.
- Latency: read issued at cycle t, write at cycle t+RD_LATENCY+1.
- Timing with start at cycle 0: reads occupy cycles 1..N, writes occupy cycles RD_LATENCY+2..N+RD_LATENCY+1, done and busy fall at N+RD_LATENCY+2, then IDLE.
- State DRAIN: wait until the pipeline is empty, then go to FINISH.
- State FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Hazards: the write address always lags the read address, and each address is read exactly once before it is written, so no read-after-write hazard exists.
- Activation functions, with x signed:
  - ReLU: x<0 ? 0 : x.
  - Leaky: x<0 ? x>>>LEAKY_SHIFT : x. Rounding is toward -inf; e.g. -1 gives -1.
  - Clip: x<0 ? 0 : (x>CLIP_MAX ? CLIP_MAX : x).
  - Passthrough: x.
- Width rules: all results fit in DATA_WIDTH with no growth; CLIP_MAX is truncated to DATA_WIDTH.
- start while busy: ignored, and does not restart the pass.
- start in the same cycle done is asserted: ignored, because FINISH is not IDLE.
- mode and active_ch changes mid-pass have no effect.

Optional Feature:
- Macro: ACT_NEG_STATS_EN.
- Defined: neg_count clears to 0 when start is accepted and increments by one for each element with x<0 as it is written. It is stable from the done cycle until the next accepted start.
- Not defined: neg_count is tied to 0 and the counter logic is absent.

Test Plan:
- Bench configuration for all scenarios: CHANNELS=2, IMG_SIZE=4, DATA_WIDTH=16, RD_LATENCY=1.
- ReLU: mode=0, active_ch=2, memory filled with {-5, 7, -32768, 0, ...} -> memory becomes {0, 7, 0, 0, ...}; done exactly at cycle 32+1+2=35 after start; one write per cycle.
- Leaky: mode=1, LEAKY_SHIFT=3, inputs {-64, -1, 100} -> {-8, -1, 100}; with ACT_NEG_STATS_EN, neg_count=2 for those three elements plus nonnegative fill.
- Clip: mode=2, CLIP_MAX=1536, inputs {2000, 1536, -3, 500} -> {1536, 1536, 0, 500}.
- Channel clamp and latency: active_ch=1 -> only addresses 0..15 are written and addresses 16..31 are untouched. active_ch=0 -> all 32 are processed. RD_LATENCY=3 -> done at cycle 32+3+2=37.
- Control: start pulsed again at cycle 10 of a pass -> ignored, single done. Reset asserted at cycle 12 -> outputs go to 0 next edge, no done, and the next start runs a full correct pass.

Source files
------------

// File: rtl/act_unit_pipe.sv
`default_nettype none
// act_unit_pipe: pipelined in-place activation (ReLU / leaky / clip / passthrough) over the CONV buffer.
// Optional macro ACT_NEG_STATS_EN enables the neg_count negative-input counter.
module act_unit_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNELS    = 8,
  parameter int IMG_SIZE    = 28,
  parameter int RD_LATENCY  = 1,
  parameter int LEAKY_SHIFT = 3,
  parameter int CLIP_MAX    = 1536,
  localparam int AW = $clog2(CHANNELS*IMG_SIZE*IMG_SIZE),
  localparam int CW = $clog2(CHANNELS+1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [CW-1:0]                active_ch,
  output logic [AW-1:0]                conv_r_addr,
  output logic                         conv_r_en,
  input  logic signed [DATA_WIDTH-1:0] conv_r_q,
  output logic [AW-1:0]                conv_w_addr,
  output logic                         conv_w_en,
  output logic                         conv_w_we,
  output logic signed [DATA_WIDTH-1:0] conv_w_d,
  output logic                         busy,
  output logic                         done,
  output logic [AW:0]                  neg_count
);

  localparam int PIX = IMG_SIZE * IMG_SIZE;
  localparam logic signed [DATA_WIDTH-1:0] CLIP_VAL = DATA_WIDTH'(CLIP_MAX);
  localparam logic [1:0] MODE_RELU  = 2'd0;
  localparam logic [1:0] MODE_LEAKY = 2'd1;
  localparam logic [1:0] MODE_CLIP  = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t                 state;
  logic [1:0]             mode_q;
  logic [AW-1:0]          last_addr;
  logic [CW-1:0]          n_ch;
  logic [AW-1:0]          last_calc;
  logic [RD_LATENCY-1:0]  vld;
  logic [AW-1:0]          vaddr [RD_LATENCY];
  logic signed [DATA_WIDTH-1:0] x;
  logic signed [DATA_WIDTH-1:0] act;
  logic                   x_neg;
  logic                   emerge;

  // Zero or out-of-range channel counts fall back to the full buffer.
  always_comb begin
    n_ch = active_ch;
    if (active_ch == '0 || int'(active_ch) > CHANNELS)
      n_ch = CW'(CHANNELS);
    last_calc = AW'(int'(n_ch) * PIX - 1);
  end

  assign x      = conv_r_q;
  assign x_neg  = x[DATA_WIDTH-1];
  assign emerge = vld[RD_LATENCY-1];

  always_comb begin
    act = x;
    case (mode_q)
      MODE_RELU:  if (x_neg) act = '0;
      MODE_LEAKY: if (x_neg) act = x >>> LEAKY_SHIFT;
      MODE_CLIP: begin
        if (x_neg)             act = '0;
        else if (x > CLIP_VAL) act = CLIP_VAL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      conv_r_en   <= 1'b0;
      conv_r_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mode_q      <= '0;
      last_addr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_q      <= mode;
          last_addr   <= last_calc;
          conv_r_addr <= '0;
          conv_r_en   <= 1'b1;
          busy        <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          if (conv_r_addr == last_addr) begin
            conv_r_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            conv_r_addr <= conv_r_addr + 1'b1;
          end
        end
        // Once no read is in flight, the final write is on the port this cycle.
        DRAIN: if (vld == '0) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FINISH;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld         <= '0;
      conv_w_en   <= 1'b0;
      conv_w_we   <= 1'b0;
      conv_w_addr <= '0;
      conv_w_d    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) vaddr[i] <= '0;
    end else begin
      vld[0]   <= conv_r_en;
      vaddr[0] <= conv_r_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i]   <= vld[i-1];
        vaddr[i] <= vaddr[i-1];
      end
      conv_w_en <= emerge;
      conv_w_we <= emerge;
      if (emerge) begin
        conv_w_addr <= vaddr[RD_LATENCY-1];
        conv_w_d    <= act;
      end
    end
  end

`ifdef ACT_NEG_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      neg_count <= '0;
    else if (state == IDLE && start)
      neg_count <= '0;
    else if (emerge && x_neg)
      neg_count <= neg_count + (AW+1)'(1);
  end
`else
  assign neg_count = '0;
`endif

endmodule
`default_nettype wire
